core_boot_loader: RTL and testbench
===================================

CORE_BOOT_LOADER -- requirements
Module: core_boot_loader

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width.
REQ-002 SHALL have parameter IMEM_DEPTH, default 64, maximum number of instruction words accepted per boot.
REQ-003 SHALL have parameter ADDR_STEP, default 4, byte increment between consecutive instruction addresses.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_start  in  1  one-cycle pulse that begins a boot sequence.
REQ-007 SHALL have port i_start_addr  in  XLEN  program base address, sampled on accepted i_start.
REQ-008 SHALL have ports i_in_valid/o_in_ready  in/out  1  valid/ready handshake for the load stream.
REQ-009 SHALL have port i_in_data  in  XLEN  instruction word or register value.
REQ-010 SHALL have port i_in_kind  in  1  0 = instruction word, 1 = register preload.
REQ-011 SHALL have port i_in_reg_addr  in  5  destination register for preloads.
REQ-012 SHALL have port i_in_last  in  1  marks the final stream beat.
REQ-013 SHALL have ports o_inst_mem_addr/o_inst_mem_data/o_inst_mem_we  out  XLEN/XLEN/1  instruction memory write port.
REQ-014 SHALL have ports o_load_reg_addr/o_load_reg_data/o_load_reg_we  out  5/XLEN/1  register file preload port.
REQ-015 SHALL have port o_setup  out  1  holds the core in setup mode while high.
REQ-016 SHALL have port o_pc_instr_start_addr  out  XLEN  start PC presented to the core.
REQ-017 SHALL have ports o_done/o_error  out  1/1  boot complete / boot failed, sticky until next i_start.
REQ-018 SHALL have port o_word_count  out  $clog2(IMEM_DEPTH)+1  instruction words written this boot.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, RELEASE, RUN, ERROR.
REQ-020 IDLE -> LOAD on i_start; SHALL latch i_start_addr and clear count, o_done and o_error.
REQ-021 In LOAD, o_in_ready SHALL be 1; a beat is accepted when i_in_valid and o_in_ready are both high in the same cycle.
REQ-022 Accepted instruction beat SHALL drive o_inst_mem_we=1 next cycle with addr = start_addr + count*ADDR_STEP, truncated to XLEN (wraps modulo 2^XLEN), and increment count.
REQ-023 Accepted preload beat SHALL drive o_load_reg_we=1 next cycle with the given address and data; count unchanged.
REQ-024 Preload to register 0 SHALL be accepted but SHALL NOT assert o_load_reg_we.
REQ-025 Instruction beat while count == IMEM_DEPTH SHALL NOT write memory and SHALL go to ERROR.
REQ-026 Accepted beat with i_in_last SHALL go LOAD -> RELEASE after its write.
REQ-027 RELEASE SHALL last exactly one cycle and then go to RUN; o_setup SHALL drop to 0 on entry to RUN and o_done SHALL rise in the same cycle.
REQ-028 o_setup SHALL be 1 in LOAD, RELEASE and ERROR, and 0 in IDLE and RUN.
REQ-029 o_pc_instr_start_addr SHALL equal the latched start address from LOAD onward.
REQ-030 i_start in LOAD or RELEASE SHALL be ignored; in RUN or ERROR it SHALL restart the sequence as from IDLE.
REQ-031 o_in_ready SHALL be 0 outside LOAD; write enables SHALL be single-cycle pulses.

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, clear count and zero every output, including o_setup, regardless of the current state (mid-load included).

Configuration
REQ-033 With BOOT_CHECKSUM_EN defined, the block SHALL add input i_expected_sum (XLEN), keep a mod-2^XLEN sum of accepted instruction words, and on the last beat go to ERROR instead of RELEASE if sum != i_expected_sum.
REQ-034 Without BOOT_CHECKSUM_EN, there SHALL be no i_expected_sum port and no checksum logic.

Structure
REQ-035 FSM state enum and the kind encodings (KIND_INSTR=0, KIND_REG=1) SHALL live in shared package core_pkg.
REQ-036 The checksum accumulator SHALL be sub-module boot_checksum, instantiated only under BOOT_CHECKSUM_EN.

Verification
REQ-037 Start addr 0x4; beats: instr 0x00127413, reg x4=0x1, instr 0x006208B3 last -> mem writes at 0x4 and 0x8, reg write x4=1, count=2, o_done=1, o_setup=0, start PC 0x4.
REQ-038 IMEM_DEPTH=4; 5 instr beats -> 4 writes, ERROR, o_error=1, o_setup held 1.
REQ-039 Start addr 0xFFFFFFFC; 2 instr beats -> writes at 0xFFFFFFFC then 0x00000000.
REQ-040 rst_n pulsed low after 1 of 3 beats -> all outputs 0 immediately, IDLE; a new i_start then gives count from 0.
REQ-041 i_in_valid toggled with stall gaps plus a preload to x0 -> only handshaked beats written, no x0 write, i_start during LOAD ignored.
REQ-042 BOOT_CHECKSUM_EN defined: words 0x1, 0x2 with i_expected_sum=0x3 -> RUN; with 0x4 -> ERROR.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : core_pkg
//  Description : Shared types for the core boot loader: the boot FSM state
//                enumeration and the load-stream beat kind encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        ERROR   = 3'd4
    } boot_state_t;

    localparam logic KIND_INSTR = 1'b0;
    localparam logic KIND_REG   = 1'b1;

endpackage : core_pkg
`default_nettype wire

// File: rtl/boot_checksum.sv
`default_nettype none
// ============================================================================
//  Module      : boot_checksum
//  Description : Running modulo-2^XLEN sum of the instruction words loaded in
//                the current boot. Only built when BOOT_CHECKSUM_EN is defined.
//  Ports       : clk, rst_n      - clock, asynchronous active-low reset
//                i_clear         - restart the sum at zero (new boot)
//                i_add_en        - add i_add_data this cycle
//                i_add_data      - word to accumulate
//                o_sum_next      - sum including the word presented this cycle
//  Macro       : BOOT_CHECKSUM_EN
//  Revision    : 1.0 - initial release
// ============================================================================
`ifdef BOOT_CHECKSUM_EN
module boot_checksum #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clear,
    input  logic            i_add_en,
    input  logic [XLEN-1:0] i_add_data,
    output logic [XLEN-1:0] o_sum_next
);

    logic [XLEN-1:0] r_sum;

    // Look-ahead value so the last beat's own word is part of the comparison
    assign o_sum_next = i_add_en ? (r_sum + i_add_data) : r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (i_clear) begin
            r_sum <= '0;
        end else begin
            r_sum <= o_sum_next;
        end
    end

endmodule : boot_checksum
`endif
`default_nettype wire

// File: rtl/core_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : core_boot_loader
//  Description : Accepts a valid/ready stream of instruction words and
//                register preloads, writes them into instruction memory and
//                the register file while holding the core in setup, then
//                releases the core at the latched start PC.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                i_start, i_start_addr      - boot request and base address
//                i_in_*, o_in_ready         - load stream handshake/payload
//                o_inst_mem_*               - instruction memory write port
//                o_load_reg_*               - register file preload port
//                o_setup                    - core held in setup while high
//                o_pc_instr_start_addr      - start PC for the core
//                o_done, o_error            - sticky boot status
//                o_word_count               - instruction words written
//                i_expected_sum             - (BOOT_CHECKSUM_EN only)
//  Macro       : BOOT_CHECKSUM_EN - adds checksum verification of the image
//  Revision    : 1.0 - initial release
// ============================================================================
module core_boot_loader
    import core_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_STEP  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_start,
    input  logic [XLEN-1:0]               i_start_addr,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic [XLEN-1:0]               i_in_data,
    input  logic                          i_in_kind,
    input  logic [4:0]                    i_in_reg_addr,
    input  logic                          i_in_last,
`ifdef BOOT_CHECKSUM_EN
    input  logic [XLEN-1:0]               i_expected_sum,
`endif
    output logic [XLEN-1:0]               o_inst_mem_addr,
    output logic [XLEN-1:0]               o_inst_mem_data,
    output logic                          o_inst_mem_we,
    output logic [4:0]                    o_load_reg_addr,
    output logic [XLEN-1:0]               o_load_reg_data,
    output logic                          o_load_reg_we,
    output logic                          o_setup,
    output logic [XLEN-1:0]               o_pc_instr_start_addr,
    output logic                          o_done,
    output logic                          o_error,
    output logic [$clog2(IMEM_DEPTH):0]   o_word_count
);

    localparam int CW = $clog2(IMEM_DEPTH) + 1;

    boot_state_t     r_state;
    boot_state_t     w_state_next;
    logic [XLEN-1:0] r_start_addr;
    logic [XLEN-1:0] r_wr_ptr;      // address of the next instruction word
    logic [CW-1:0]   r_count;

    logic w_accept;
    logic w_instr_beat;
    logic w_full;
    logic w_mem_write;
    logic w_reg_write;
    logic w_start;
    logic w_sum_ok;

    assign w_accept     = i_in_valid && (r_state == LOAD);
    assign w_instr_beat = w_accept && (i_in_kind == KIND_INSTR);
    assign w_full       = (r_count == CW'(IMEM_DEPTH));
    assign w_mem_write  = w_instr_beat && !w_full;
    // Register 0 is hard-wired in the core, so its preload is swallowed
    assign w_reg_write  = w_accept && (i_in_kind == KIND_REG) && (i_in_reg_addr != 5'd0);
    assign w_start      = (w_state_next == LOAD) && (r_state != LOAD);

`ifdef BOOT_CHECKSUM_EN
    logic [XLEN-1:0] w_sum_next;

    boot_checksum #(
        .XLEN       (XLEN)
    ) u_boot_checksum (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_start),
        .i_add_en   (w_mem_write),
        .i_add_data (i_in_data),
        .o_sum_next (w_sum_next)
    );

    assign w_sum_ok = (w_sum_next == i_expected_sum);
`else
    assign w_sum_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_in_ready   = 1'b0;
        o_setup      = 1'b0;
        o_done       = 1'b0;
        o_error      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) w_state_next = LOAD;
            end
            LOAD: begin
                o_in_ready = 1'b1;
                o_setup    = 1'b1;
                // Overflow wins over end-of-stream: the excess word is dropped
                if (w_instr_beat && w_full) begin
                    w_state_next = ERROR;
                end else if (w_accept && i_in_last) begin
                    w_state_next = w_sum_ok ? RELEASE : ERROR;
                end
            end
            RELEASE: begin
                o_setup      = 1'b1;
                w_state_next = RUN;
            end
            RUN: begin
                o_done = 1'b1;
                if (i_start) w_state_next = LOAD;
            end
            ERROR: begin
                o_setup = 1'b1;
                o_error = 1'b1;
                if (i_start) w_state_next = LOAD;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_addr    <= '0;
            r_wr_ptr        <= '0;
            r_count         <= '0;
            o_inst_mem_addr <= '0;
            o_inst_mem_data <= '0;
            o_inst_mem_we   <= 1'b0;
            o_load_reg_addr <= '0;
            o_load_reg_data <= '0;
            o_load_reg_we   <= 1'b0;
        end else begin
            o_inst_mem_we <= 1'b0;
            o_load_reg_we <= 1'b0;
            if (w_start) begin
                r_start_addr <= i_start_addr;
                r_wr_ptr     <= i_start_addr;
                r_count      <= '0;
            end
            if (w_mem_write) begin
                o_inst_mem_we   <= 1'b1;
                o_inst_mem_addr <= r_wr_ptr;
                o_inst_mem_data <= i_in_data;
                r_wr_ptr        <= r_wr_ptr + XLEN'(ADDR_STEP);  // wraps mod 2^XLEN
                r_count         <= r_count + CW'(1);
            end
            if (w_reg_write) begin
                o_load_reg_we   <= 1'b1;
                o_load_reg_addr <= i_in_reg_addr;
                o_load_reg_data <= i_in_data;
            end
        end
    end

    assign o_pc_instr_start_addr = r_start_addr;
    assign o_word_count          = r_count;

endmodule : core_boot_loader
`default_nettype wire

// File: tb/tb_core_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_boot_loader
//  Description : Self-checking bench for core_boot_loader (IMEM_DEPTH = 4).
//                A transaction-level model predicts every output each cycle;
//                directed scenarios pin the model with literal values, then
//                randomized boots exercise gaps, preloads and overflow.
//  Macro       : BOOT_CHECKSUM_EN (bench follows the DUT configuration)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_boot_loader;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int STEP  = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    localparam int P_IDLE = 0, P_LOAD = 1, P_REL = 2, P_RUN = 3, P_ERR = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            i_start = 1'b0;
    logic [XLEN-1:0] i_start_addr = '0;
    logic            i_in_valid = 1'b0;
    logic            o_in_ready;
    logic [XLEN-1:0] i_in_data = '0;
    logic            i_in_kind = 1'b0;
    logic [4:0]      i_in_reg_addr = '0;
    logic            i_in_last = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    logic [XLEN-1:0] i_expected_sum = '0;
`endif
    logic [XLEN-1:0] o_inst_mem_addr, o_inst_mem_data;
    logic            o_inst_mem_we;
    logic [4:0]      o_load_reg_addr;
    logic [XLEN-1:0] o_load_reg_data;
    logic            o_load_reg_we, o_setup, o_done, o_error;
    logic [XLEN-1:0] o_pc_instr_start_addr;
    logic [CW-1:0]   o_word_count;

    core_boot_loader #(.XLEN(XLEN), .IMEM_DEPTH(DEPTH), .ADDR_STEP(STEP)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .i_start               (i_start),
        .i_start_addr          (i_start_addr),
        .i_in_valid            (i_in_valid),
        .o_in_ready            (o_in_ready),
        .i_in_data             (i_in_data),
        .i_in_kind             (i_in_kind),
        .i_in_reg_addr         (i_in_reg_addr),
        .i_in_last             (i_in_last),
`ifdef BOOT_CHECKSUM_EN
        .i_expected_sum        (i_expected_sum),
`endif
        .o_inst_mem_addr       (o_inst_mem_addr),
        .o_inst_mem_data       (o_inst_mem_data),
        .o_inst_mem_we         (o_inst_mem_we),
        .o_load_reg_addr       (o_load_reg_addr),
        .o_load_reg_data       (o_load_reg_data),
        .o_load_reg_we         (o_load_reg_we),
        .o_setup               (o_setup),
        .o_pc_instr_start_addr (o_pc_instr_start_addr),
        .o_done                (o_done),
        .o_error               (o_error),
        .o_word_count          (o_word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int              m_phase;
    logic [XLEN-1:0] m_base, m_sum;
    int              m_cnt;
    bit              m_mwe, m_rwe;
    logic [XLEN-1:0] m_maddr, m_mdata, m_rdata;
    logic [4:0]      m_raddr;

    function automatic bit sum_ok(input logic [XLEN-1:0] s);
`ifdef BOOT_CHECKSUM_EN
        return s == i_expected_sum;
`else
        return s == s;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= P_IDLE; m_base <= '0; m_cnt <= 0; m_sum <= '0;
            m_mwe <= 1'b0; m_rwe <= 1'b0;
        end else begin
            m_mwe <= 1'b0;
            m_rwe <= 1'b0;
            case (m_phase)
                P_LOAD: if (i_in_valid) begin
                    if (i_in_kind == 1'b0) begin
                        if (m_cnt == DEPTH) m_phase <= P_ERR;
                        else begin
                            m_mwe   <= 1'b1;
                            m_maddr <= m_base + 32'(m_cnt * STEP);
                            m_mdata <= i_in_data;
                            m_cnt   <= m_cnt + 1;
                            m_sum   <= m_sum + i_in_data;
                            if (i_in_last) m_phase <= sum_ok(m_sum + i_in_data) ? P_REL : P_ERR;
                        end
                    end else begin
                        if (i_in_reg_addr != 5'd0) begin
                            m_rwe <= 1'b1; m_raddr <= i_in_reg_addr; m_rdata <= i_in_data;
                        end
                        if (i_in_last) m_phase <= sum_ok(m_sum) ? P_REL : P_ERR;
                    end
                end
                P_REL: m_phase <= P_RUN;
                default: if (i_start) begin
                    m_phase <= P_LOAD; m_base <= i_start_addr; m_cnt <= 0; m_sum <= '0;
                end
            endcase
        end
    end

    typedef struct { logic [XLEN-1:0] a; logic [XLEN-1:0] d; } wr_t;
    wr_t mem_log[$];
    wr_t reg_log[$];

    // Per-cycle compare against the model, plus write logging
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("ready",  o_in_ready, m_phase == P_LOAD);
            chk("setup",  o_setup, (m_phase == P_LOAD) || (m_phase == P_REL) || (m_phase == P_ERR));
            chk("done",   o_done,  m_phase == P_RUN);
            chk("error",  o_error, m_phase == P_ERR);
            chk("count",  o_word_count, m_cnt);
            chk("mem_we", o_inst_mem_we, m_mwe);
            chk("reg_we", o_load_reg_we, m_rwe);
            if (m_phase != P_IDLE) chk("pc", o_pc_instr_start_addr, m_base);
            if (m_mwe) begin
                chk("mem_addr", o_inst_mem_addr, m_maddr);
                chk("mem_data", o_inst_mem_data, m_mdata);
            end
            if (m_rwe) begin
                chk("reg_addr", o_load_reg_addr, m_raddr);
                chk("reg_data", o_load_reg_data, m_rdata);
            end
        end
        if (rst_n && o_inst_mem_we) mem_log.push_back('{o_inst_mem_addr, o_inst_mem_data});
        if (rst_n && o_load_reg_we) reg_log.push_back('{32'(o_load_reg_addr), o_load_reg_data});
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [XLEN-1:0] a);
        i_start = 1'b1; i_start_addr = a;
        cyc();
        i_start = 1'b0;
    endtask

    task automatic send_beat(input logic kind, input logic [XLEN-1:0] d,
                             input logic [4:0] ra, input logic last);
        i_in_valid = 1'b1; i_in_kind = kind; i_in_data = d;
        i_in_reg_addr = ra; i_in_last = last;
        cyc();
        i_in_valid = 1'b0; i_in_last = 1'b0;
    endtask

    task automatic wait_end();
        int t = 0;
        while (!(o_done || o_error) && t < 20) begin
            cyc();
            t++;
        end
        chk("boot_end_timeout", o_done | o_error, 1);
    endtask

    task automatic clear_logs();
        mem_log.delete();
        reg_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        cmp_en = 1'b1;

        // reset state
        chk("rst_setup", o_setup, 0);
        chk("rst_ready", o_in_ready, 0);
        chk("rst_done", o_done, 0);
        chk("rst_count", o_word_count, 0);

        // basic boot with a preload
        clear_logs();
        pulse_start(32'h4);
        send_beat(1'b0, 32'h00127413, 5'd0, 1'b0);
        send_beat(1'b1, 32'h1, 5'd4, 1'b0);
        send_beat(1'b0, 32'h006208B3, 5'd0, 1'b1);
        cyc();
        chk("t1_nmem", mem_log.size(), 2);
        if (mem_log.size() == 2) begin
            chk("t1_a0", mem_log[0].a, 32'h4);
            chk("t1_d0", mem_log[0].d, 32'h00127413);
            chk("t1_a1", mem_log[1].a, 32'h8);
            chk("t1_d1", mem_log[1].d, 32'h006208B3);
        end
        chk("t1_nreg", reg_log.size(), 1);
        if (reg_log.size() == 1) chk("t1_reg", {reg_log[0].a, reg_log[0].d}, {32'd4, 32'd1});
        chk("t1_count", o_word_count, 2);
        chk("t1_done", o_done, 1);
        chk("t1_setup", o_setup, 0);
        chk("t1_pc", o_pc_instr_start_addr, 32'h4);

        // overflow of the instruction memory
        clear_logs();
        pulse_start(32'h0);
        for (int k = 0; k < 5; k++) send_beat(1'b0, 32'(k + 16), 5'd0, k == 4);
        cyc();
        chk("t2_nmem", mem_log.size(), 4);
        chk("t2_error", o_error, 1);
        chk("t2_setup", o_setup, 1);
        chk("t2_done", o_done, 0);

        // address wrap
        clear_logs();
        pulse_start(32'hFFFF_FFFC);
        send_beat(1'b0, 32'hA, 5'd0, 1'b0);
        send_beat(1'b0, 32'hB, 5'd0, 1'b1);
        cyc();
        chk("t3_nmem", mem_log.size(), 2);
        if (mem_log.size() == 2) begin
            chk("t3_a0", mem_log[0].a, 32'hFFFF_FFFC);
            chk("t3_a1", mem_log[1].a, 32'h0);
        end

        // asynchronous reset mid-load
        pulse_start(32'h100);
        send_beat(1'b0, 32'h55, 5'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_outs", {o_setup, o_in_ready, o_done, o_error, o_inst_mem_we, o_load_reg_we},
            6'b0);
        chk("t4_rst_count", o_word_count, 0);
        chk("t4_rst_pc", o_pc_instr_start_addr, 0);
        chk("t4_rst_mem", {o_inst_mem_addr, o_inst_mem_data}, 64'h0);
        chk("t4_rst_reg", {27'd0, o_load_reg_addr, o_load_reg_data}, 64'h0);
        #1 rst_n = 1'b1;
        cyc();
        clear_logs();
        pulse_start(32'h200);
        send_beat(1'b0, 32'h77, 5'd0, 1'b1);
        cyc();
        chk("t4_count", o_word_count, 1);
        if (mem_log.size() > 0) chk("t4_addr", mem_log[0].a, 32'h200);
        else chk("t4_nmem", mem_log.size(), 1);

        // stalls, x0 preload, ignored start during LOAD
        clear_logs();
        pulse_start(32'h40);
        send_beat(1'b0, 32'h1111, 5'd0, 1'b0);
        i_in_data = 32'hDEAD; cyc(); cyc();
        pulse_start(32'h999);
        send_beat(1'b1, 32'hBEEF, 5'd0, 1'b0);
        cyc();
        send_beat(1'b1, 32'h3333, 5'd3, 1'b0);
        send_beat(1'b0, 32'h2222, 5'd0, 1'b1);
        cyc();
        chk("t5_nmem", mem_log.size(), 2);
        chk("t5_nreg", reg_log.size(), 1);
        if (reg_log.size() == 1) chk("t5_reg", reg_log[0].a, 3);
        chk("t5_pc", o_pc_instr_start_addr, 32'h40);
        chk("t5_done", o_done, 1);

`ifdef BOOT_CHECKSUM_EN
        i_expected_sum = 32'h3;
        pulse_start(32'h0);
        send_beat(1'b0, 32'h1, 5'd0, 1'b0);
        send_beat(1'b0, 32'h2, 5'd0, 1'b1);
        cyc();
        chk("cs_ok_done", o_done, 1);
        i_expected_sum = 32'h4;
        pulse_start(32'h0);
        send_beat(1'b0, 32'h1, 5'd0, 1'b0);
        send_beat(1'b0, 32'h2, 5'd0, 1'b1);
        cyc();
        chk("cs_bad_error", o_error, 1);
`endif

        // randomized boots
        for (int b = 0; b < 60; b++) begin
            int n;
`ifdef BOOT_CHECKSUM_EN
            logic [XLEN-1:0] sum = '0;
`endif
            pulse_start($urandom);
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                logic            kind;
                logic [XLEN-1:0] d;
                repeat ($urandom_range(0, 2)) cyc();
                kind = ($urandom_range(0, 3) == 0);
                d    = $urandom;
`ifdef BOOT_CHECKSUM_EN
                if (!kind) sum = sum + d;
                if (k == n - 1) i_expected_sum = ($urandom_range(0, 1) == 1) ? sum : sum ^ 32'h1;
`endif
                if (k < n - 1 && $urandom_range(0, 7) == 0) begin
                    i_start = 1'b1; i_start_addr = $urandom;
                end
                send_beat(kind, d, 5'($urandom_range(0, 7)), k == n - 1);
                i_start = 1'b0;
            end
            wait_end();
            repeat ($urandom_range(0, 3)) cyc();
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_core_boot_loader
`default_nettype wire
